// File: rtl/window_sum_decoder_if.sv
// window_sum_decoder_if: sample-in / sample-out bundle for the window-sum decoder
interface window_sum_decoder_if #(parameter int DW = 8);
    logic          clr;
    logic          in_valid;
    logic [DW-1:0] inp;
    logic          out_valid;
    logic [DW-1:0] outp;
    logic          primed;
    modport master (output clr, in_valid, inp, input out_valid, outp, primed);
    modport slave  (input clr, in_valid, inp, output out_valid, outp, primed);
endinterface

// File: rtl/window_sum_decoder.sv
// window_sum_decoder: recovers x[n] from a sliding W-sample window sum y[n]
module window_sum_decoder #(
    parameter int W  = 4,
    parameter int DW = 8
) (
    input logic clk,
    input logic rst,
    window_sum_decoder_if.slave bus
);
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);
    localparam logic [CW-1:0] FULL = CW'(W);

    typedef enum logic {PRIME, STEADY} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [DW-1:0] y_prev, x;
    logic [DW-1:0] hist [W];

    assign bus.primed = state == STEADY;

    // A clear makes the current sample the first of a fresh stream, so its history is all zero
    always_comb begin
        x = bus.clr ? bus.inp : bus.inp - y_prev + hist[W-1];
        cnt_next = bus.clr ? {{(CW-1){1'b0}}, bus.in_valid}
                 : (bus.in_valid && cnt != FULL) ? cnt + 1'b1 : cnt;
        state_next = bus.clr ? PRIME
                   : (bus.in_valid && cnt == LAST) ? STEADY : state;
    end

    // Control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= PRIME;
        else     state <= state_next;
    end

    // Datapath: previous sum, decoded history shift register and registered output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_prev        <= '0;
            bus.outp      <= '0;
            bus.out_valid <= 1'b0;
            cnt           <= '0;
            for (int i = 0; i < W; i++) hist[i] <= '0;
        end else begin
            bus.out_valid <= bus.in_valid;
            cnt           <= cnt_next;
            if (bus.in_valid) begin
                y_prev   <= bus.inp;
                bus.outp <= x;
                hist[0]  <= x;
                for (int i = 1; i < W; i++) hist[i] <= bus.clr ? '0 : hist[i-1];
            end else if (bus.clr) begin
                y_prev <= '0;
                for (int i = 0; i < W; i++) hist[i] <= '0;
            end
        end
    end
endmodule

// File: tb/tb_window_sum_decoder.sv
// tb_window_sum_decoder: scoreboard bench with a reference window-sum encoder
module tb_window_sum_decoder;
    localparam int W  = 4;
    localparam int DW = 8;

    typedef struct {
        logic [DW-1:0] x;
        logic          primed;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t sb [$];

    window_sum_decoder_if #(.DW(DW)) bus ();

    window_sum_decoder #(.W(W), .DW(DW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle of inputs; expected results are queued by the caller
    task automatic cyc(input logic v, input logic c, input logic [DW-1:0] y);
        bus.in_valid = v;
        bus.clr      = c;
        bus.inp      = y;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.clr      = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] x, input logic p);
        exp_t e;
        e.x      = x;
        e.primed = p;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        cyc(1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, '0);
        check(name, sb.size(), 0);
    endtask

    // Monitor: every presented output must match the oldest expected sample
    always @(negedge clk) begin
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out_valid: got outp=%0d expected no output at %0t", bus.outp, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("outp", int'(bus.outp), int'(e.x));
                check("primed", int'(bus.primed), int'(e.primed));
            end
        end
    end

    initial begin
        int win [$];
        int cnt;
        int sum;
        logic [DW-1:0] xr, yr;
        logic v, c;
        logic [DW-1:0] y27 [5] = '{8'd1, 8'd3, 8'd6, 8'd10, 8'd14};
        bus.in_valid = 1'b0;
        bus.clr      = 1'b0;
        bus.inp      = '0;
        #2;
        check("reset_outp", int'(bus.outp), 0);
        check("reset_out_valid", int'(bus.out_valid), 0);
        check("reset_primed", int'(bus.primed), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            push(DW'(i + 1), i >= W - 1);
            cyc(1'b1, 1'b0, y27[i]);
        end
        #6;
        rst = 1'b1;
        #1;
        check("async_rst_outp", int'(bus.outp), 0);
        check("async_rst_out_valid", int'(bus.out_valid), 0);
        check("async_rst_primed", int'(bus.primed), 0);
        #1;
        rst = 1'b0;
        push(8'd5, 1'b0);
        cyc(1'b1, 1'b0, 8'd5);

        cyc(1'b0, 1'b1, '0);
        push(8'd200, 1'b0);
        cyc(1'b1, 1'b0, 8'd200);
        push(8'd200, 1'b0);
        cyc(1'b1, 1'b0, 8'd144);
        drain("wrap_drain");

        cyc(1'b0, 1'b1, '0);
        for (int i = 0; i < 3; i++) begin
            push(DW'(i + 1), 1'b0);
            cyc(1'b1, 1'b0, y27[i]);
            for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 8'hff);
        end
        drain("gap_drain");

        cyc(1'b0, 1'b1, '0);
        for (int i = 0; i < 4; i++) begin
            push(DW'(i + 1), i == 3);
            cyc(1'b1, 1'b0, y27[i]);
        end
        push(8'd7, 1'b0);
        cyc(1'b1, 1'b1, 8'd7);
        push(8'd2, 1'b0);
        cyc(1'b1, 1'b0, 8'd9);
        cyc(1'b0, 1'b1, '0);
        check("clr_idle_outp_hold", int'(bus.outp), 2);
        check("clr_idle_primed", int'(bus.primed), 0);
        drain("clr_drain");

        win = {};
        cnt = 0;
        for (int n = 0; n < 1000; n++) begin
            v  = $urandom_range(0, 9) < 7;
            c  = $urandom_range(0, 19) == 0;
            xr = DW'($urandom);
            if (c) begin
                win = {};
                cnt = 0;
            end
            if (v) begin
                win.push_back(int'(xr));
                if (win.size() > W) void'(win.pop_front());
                sum = 0;
                foreach (win[j]) sum += win[j];
                yr = DW'(sum);
                if (cnt < W) cnt++;
                push(xr, cnt >= W);
            end else begin
                yr = DW'($urandom);
            end
            cyc(v, c, yr);
        end
        drain("random_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
